// File: rtl/pkt_pkg.sv
// Shared definitions for the buffered packet link: default field widths,
// the packet type enum and the packet record used across node links.
package pkt_pkg;

    localparam int PKT_QOS_W  = 1;
    localparam int PKT_ID_W   = 6;
    localparam int PKT_FLIT_W = 8;
    localparam int TYPE_W     = 2;

    typedef enum logic [TYPE_W-1:0] {
        PKT_REQ  = 2'd0,
        PKT_RESP = 2'd1,
        PKT_WR   = 2'd2,
        PKT_CTRL = 2'd3
    } pkt_type_e;

    typedef struct packed {
        logic [PKT_QOS_W-1:0]  qos;
        pkt_type_e             ptype;
        logic [PKT_ID_W-1:0]   src;
        logic [PKT_ID_W-1:0]   tgt;
        logic [PKT_FLIT_W-1:0] data;
    } pkt_t;

endpackage

// File: rtl/pkt_qos_fifo.sv
// One link channel: separate high/low class FIFOs, QoS selection with a
// bounded-starvation counter for the low class, and a selection lock that
// keeps the presented packet stable while the consumer stalls.
module pkt_qos_fifo
    import pkt_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int QOS_W      = 1,
    parameter int ID_W       = 6,
    parameter int FLIT_W     = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [QOS_W-1:0]  in_qos,
    input  logic [TYPE_W-1:0] in_type,
    input  logic [ID_W-1:0]   in_src,
    input  logic [ID_W-1:0]   in_tgt,
    input  logic [FLIT_W-1:0] in_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [QOS_W-1:0]  out_qos,
    output logic [TYPE_W-1:0] out_type,
    output logic [ID_W-1:0]   out_src,
    output logic [ID_W-1:0]   out_tgt,
    output logic [FLIT_W-1:0] out_data,
    output logic              starve_evt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = QOS_W + TYPE_W + 2 * ID_W + FLIT_W;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STV_ZERO  = STV_W'(0);
    localparam logic [STV_W-1:0] STV_ONE   = STV_W'(1);
    localparam logic [STV_W-1:0] STARVE_C  = STV_W'(STARVE_MAX);
    localparam logic [QOS_W-1:0] QOS_ZERO  = QOS_W'(0);

    logic [ENT_W-1:0] hi_mem_r [DEPTH];
    logic [ENT_W-1:0] lo_mem_r [DEPTH];
    logic [PTR_W-1:0] hi_wp_r, hi_rp_r, lo_wp_r, lo_rp_r;
    logic [CNT_W-1:0] hi_cnt_r, lo_cnt_r;
    logic [STV_W-1:0] starve_r;
    logic             lock_r, lock_hi_r, lock_forced_r;

    logic [ENT_W-1:0] in_ent_s, head_s;
    logic             push_s, push_hi_s, push_lo_s;
    logic             pop_s, pop_hi_s, pop_lo_s;
    logic             sel_hi_s, forced_s;
    logic             hi_any_s, lo_any_s;

    assign hi_any_s  = (hi_cnt_r != CNT_ZERO);
    assign lo_any_s  = (lo_cnt_r != CNT_ZERO);

    // Handshake only looks at registered counts, so in_rdy never depends on in_vld or out_rdy.
    assign in_rdy    = ~rst & (hi_cnt_r < DEPTH_C) & (lo_cnt_r < DEPTH_C);
    assign out_vld   = ~rst & (hi_any_s | lo_any_s);

    assign in_ent_s  = {in_qos, in_type, in_src, in_tgt, in_data};
    assign push_s    = in_vld & in_rdy;
    assign push_hi_s = push_s & (in_qos != QOS_ZERO);
    assign push_lo_s = push_s & (in_qos == QOS_ZERO);
    assign pop_s     = out_vld & out_rdy;
    assign pop_hi_s  = pop_s & sel_hi_s;
    assign pop_lo_s  = pop_s & ~sel_hi_s;

    // Pick the class to present; a locked selection overrides the live QoS decision.
    always_comb begin
        sel_hi_s = 1'b0;
        forced_s = 1'b0;
        if (lock_r) begin
            sel_hi_s = lock_hi_r;
            forced_s = lock_forced_r;
        end else begin
            sel_hi_s = hi_any_s & (~lo_any_s | (starve_r < STARVE_C));
            forced_s = ~sel_hi_s & hi_any_s;
        end
    end

    // Present the head of the selected FIFO.
    always_comb begin
        head_s = lo_mem_r[lo_rp_r];
        if (sel_hi_s) begin
            head_s = hi_mem_r[hi_rp_r];
        end else begin
            head_s = lo_mem_r[lo_rp_r];
        end
    end

    assign {out_qos, out_type, out_src, out_tgt, out_data} = head_s;

    // A low pop only counts as starvation relief if high traffic was waiting when it was chosen.
    assign starve_evt = pop_lo_s & forced_s;

    // Payload storage; contents need no reset because pointers and counts gate visibility.
    always_ff @(posedge clk) begin
        if (push_hi_s) begin
            hi_mem_r[hi_wp_r] <= in_ent_s;
        end
        if (push_lo_s) begin
            lo_mem_r[lo_wp_r] <= in_ent_s;
        end
    end

    // Pointers, counts, starvation counter and selection lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_wp_r       <= PTR_ZERO;
            hi_rp_r       <= PTR_ZERO;
            lo_wp_r       <= PTR_ZERO;
            lo_rp_r       <= PTR_ZERO;
            hi_cnt_r      <= CNT_ZERO;
            lo_cnt_r      <= CNT_ZERO;
            starve_r      <= STV_ZERO;
            lock_r        <= 1'b0;
            lock_hi_r     <= 1'b0;
            lock_forced_r <= 1'b0;
        end else begin
            if (push_hi_s) hi_wp_r <= hi_wp_r + PTR_ONE;
            if (push_lo_s) lo_wp_r <= lo_wp_r + PTR_ONE;
            if (pop_hi_s)  hi_rp_r <= hi_rp_r + PTR_ONE;
            if (pop_lo_s)  lo_rp_r <= lo_rp_r + PTR_ONE;

            hi_cnt_r <= hi_cnt_r + CNT_W'(push_hi_s) - CNT_W'(pop_hi_s);
            lo_cnt_r <= lo_cnt_r + CNT_W'(push_lo_s) - CNT_W'(pop_lo_s);

            if (!lo_any_s || pop_lo_s) begin
                starve_r <= STV_ZERO;
            end else if (pop_hi_s && (starve_r < STARVE_C)) begin
                starve_r <= starve_r + STV_ONE;
            end

            if (pop_s) begin
                lock_r <= 1'b0;
            end else if (out_vld) begin
                lock_r        <= 1'b1;
                lock_hi_r     <= sel_hi_s;
                lock_forced_r <= forced_s;
            end
        end
    end

endmodule

// File: rtl/pkt_link_qbuf.sv
// QoS-aware buffered link stage: NUM_CH independent channels, each a
// pkt_qos_fifo. This level only fans the per-channel ports out.
module pkt_link_qbuf
    import pkt_pkg::*;
#(
    parameter int NUM_CH     = 7,
    parameter int DEPTH      = 4,
    parameter int QOS_W      = 1,
    parameter int ID_W       = 6,
    parameter int FLIT_W     = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld     [NUM_CH-1:0],
    output logic              in_rdy     [NUM_CH-1:0],
    input  logic [QOS_W-1:0]  in_qos     [NUM_CH-1:0],
    input  logic [TYPE_W-1:0] in_type    [NUM_CH-1:0],
    input  logic [ID_W-1:0]   in_src     [NUM_CH-1:0],
    input  logic [ID_W-1:0]   in_tgt     [NUM_CH-1:0],
    input  logic [FLIT_W-1:0] in_data    [NUM_CH-1:0],
    output logic              out_vld    [NUM_CH-1:0],
    input  logic              out_rdy    [NUM_CH-1:0],
    output logic [QOS_W-1:0]  out_qos    [NUM_CH-1:0],
    output logic [TYPE_W-1:0] out_type   [NUM_CH-1:0],
    output logic [ID_W-1:0]   out_src    [NUM_CH-1:0],
    output logic [ID_W-1:0]   out_tgt    [NUM_CH-1:0],
    output logic [FLIT_W-1:0] out_data   [NUM_CH-1:0],
    output logic              starve_evt [NUM_CH-1:0]
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pkt_qos_fifo #(
            .DEPTH      (DEPTH),
            .QOS_W      (QOS_W),
            .ID_W       (ID_W),
            .FLIT_W     (FLIT_W),
            .STARVE_MAX (STARVE_MAX)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .in_vld     (in_vld[g]),
            .in_rdy     (in_rdy[g]),
            .in_qos     (in_qos[g]),
            .in_type    (in_type[g]),
            .in_src     (in_src[g]),
            .in_tgt     (in_tgt[g]),
            .in_data    (in_data[g]),
            .out_vld    (out_vld[g]),
            .out_rdy    (out_rdy[g]),
            .out_qos    (out_qos[g]),
            .out_type   (out_type[g]),
            .out_src    (out_src[g]),
            .out_tgt    (out_tgt[g]),
            .out_data   (out_data[g]),
            .starve_evt (starve_evt[g])
        );
    end

endmodule

// File: tb/tb_pkt_link_qbuf.sv
// Self-checking bench for pkt_link_qbuf: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pkt_link_qbuf;
    import pkt_pkg::*;

    localparam int NUM_CH     = 7;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic                  clk, rst;
    logic                  in_vld     [NUM_CH-1:0];
    logic                  in_rdy     [NUM_CH-1:0];
    logic [PKT_QOS_W-1:0]  in_qos     [NUM_CH-1:0];
    logic [TYPE_W-1:0]     in_type    [NUM_CH-1:0];
    logic [PKT_ID_W-1:0]   in_src     [NUM_CH-1:0];
    logic [PKT_ID_W-1:0]   in_tgt     [NUM_CH-1:0];
    logic [PKT_FLIT_W-1:0] in_data    [NUM_CH-1:0];
    logic                  out_vld    [NUM_CH-1:0];
    logic                  out_rdy    [NUM_CH-1:0];
    logic [PKT_QOS_W-1:0]  out_qos    [NUM_CH-1:0];
    logic [TYPE_W-1:0]     out_type   [NUM_CH-1:0];
    logic [PKT_ID_W-1:0]   out_src    [NUM_CH-1:0];
    logic [PKT_ID_W-1:0]   out_tgt    [NUM_CH-1:0];
    logic [PKT_FLIT_W-1:0] out_data   [NUM_CH-1:0];
    logic                  starve_evt [NUM_CH-1:0];

    pkt_link_qbuf #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .QOS_W(PKT_QOS_W), .ID_W(PKT_ID_W),
        .FLIT_W(PKT_FLIT_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_qos(in_qos), .in_type(in_type),
        .in_src(in_src), .in_tgt(in_tgt), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_qos(out_qos), .out_type(out_type),
        .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data),
        .starve_evt(starve_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-class packet queues plus the spec's selection state.
    pkt_t hq [NUM_CH][$];
    pkt_t lq [NUM_CH][$];
    int   starve_m  [NUM_CH];
    bit   lock_m    [NUM_CH];
    bit   lock_hi_m [NUM_CH];
    bit   lock_f_m  [NUM_CH];
    bit   m_rdy     [NUM_CH];
    bit   m_vld     [NUM_CH];
    bit   m_sel_hi  [NUM_CH];
    bit   m_forced  [NUM_CH];
    bit   m_rst;

    typedef struct {
        int   ch;
        pkt_t in_p;
        pkt_t exp_p;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h at %0t", name, ch, act, exp, $time);
        end
    endtask

    function automatic pkt_t dut_pkt(input int c);
        pkt_t p;
        p.qos   = out_qos[c];
        p.ptype = pkt_type_e'(out_type[c]);
        p.src   = out_src[c];
        p.tgt   = out_tgt[c];
        p.data  = out_data[c];
        return p;
    endfunction

    task automatic drive(input int c, input pkt_t p);
        in_vld[c]  = 1'b1;
        in_qos[c]  = p.qos;
        in_type[c] = p.ptype;
        in_src[c]  = p.src;
        in_tgt[c]  = p.tgt;
        in_data[c] = p.data;
    endtask

    task automatic idle_all();
        for (int c = 0; c < NUM_CH; c++) in_vld[c] = 1'b0;
    endtask

    function automatic pkt_t mk(input logic q, input logic [7:0] d);
        pkt_t p;
        p.qos = q; p.ptype = PKT_WR; p.src = 6'd1; p.tgt = 6'd2; p.data = d;
        return p;
    endfunction

    // Compare DUT against the model shortly after inputs settle (away from the edge).
    task automatic settle();
        #2;
        m_rst = rst;
        for (int c = 0; c < NUM_CH; c++) begin
            m_rdy[c] = !rst && (hq[c].size() < DEPTH) && (lq[c].size() < DEPTH);
            m_vld[c] = !rst && (hq[c].size() != 0 || lq[c].size() != 0);
            if (lock_m[c]) begin
                m_sel_hi[c] = lock_hi_m[c];
                m_forced[c] = lock_f_m[c];
            end else begin
                m_sel_hi[c] = (hq[c].size() != 0) && (lq[c].size() == 0 || starve_m[c] < STARVE_MAX);
                m_forced[c] = !m_sel_hi[c] && (hq[c].size() != 0);
            end
            chk("in_rdy", c, in_rdy[c], m_rdy[c]);
            chk("out_vld", c, out_vld[c], m_vld[c]);
            chk("starve_evt", c, starve_evt[c], m_vld[c] && out_rdy[c] && !m_sel_hi[c] && m_forced[c]);
            if (m_vld[c]) chk("out_pkt", c, dut_pkt(c), m_sel_hi[c] ? hq[c][0] : lq[c][0]);
        end
    endtask

    // Advance one clock and apply the same transfer to the model.
    task automatic tick();
        bit   push, pop;
        pkt_t p;
        @(posedge clk);
        if (m_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hq[c].delete(); lq[c].delete();
                starve_m[c] = 0; lock_m[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                push = in_vld[c] && m_rdy[c];
                pop  = m_vld[c] && out_rdy[c];
                if (lq[c].size() == 0 || (pop && !m_sel_hi[c])) starve_m[c] = 0;
                else if (pop && m_sel_hi[c] && starve_m[c] < STARVE_MAX) starve_m[c]++;
                if (pop) lock_m[c] = 1'b0;
                else if (m_vld[c]) begin
                    lock_m[c] = 1'b1; lock_hi_m[c] = m_sel_hi[c]; lock_f_m[c] = m_forced[c];
                end
                if (pop) begin
                    if (m_sel_hi[c]) void'(hq[c].pop_front());
                    else void'(lq[c].pop_front());
                end
                if (push) begin
                    p.qos = in_qos[c]; p.ptype = pkt_type_e'(in_type[c]);
                    p.src = in_src[c]; p.tgt = in_tgt[c]; p.data = in_data[c];
                    if (in_qos[c] != 1'b0) hq[c].push_back(p);
                    else lq[c].push_back(p);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    logic [7:0] st_d [5];
    logic       st_e [5];

    initial begin
        vecs[0] = '{3, '{1'b0, PKT_REQ,  6'd5,  6'd12, 8'hA5}, '{1'b0, PKT_REQ,  6'd5,  6'd12, 8'hA5}};
        vecs[1] = '{0, '{1'b1, PKT_RESP, 6'd63, 6'd0,  8'hFF}, '{1'b1, PKT_RESP, 6'd63, 6'd0,  8'hFF}};
        vecs[2] = '{6, '{1'b0, PKT_WR,   6'd1,  6'd2,  8'h00}, '{1'b0, PKT_WR,   6'd1,  6'd2,  8'h00}};
        vecs[3] = '{2, '{1'b1, PKT_CTRL, 6'd33, 6'd44, 8'h5A}, '{1'b1, PKT_CTRL, 6'd33, 6'd44, 8'h5A}};
        vecs[4] = '{5, '{1'b0, PKT_REQ,  6'd0,  6'd63, 8'h3C}, '{1'b0, PKT_REQ,  6'd0,  6'd63, 8'h3C}};
        st_d = '{8'd1, 8'd2, 8'd3, 8'h80, 8'd4};
        st_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            in_vld[c] = 1'b0; in_qos[c] = 1'b0; in_type[c] = 2'd0;
            in_src[c] = 6'd0; in_tgt[c] = 6'd0; in_data[c] = 8'd0; out_rdy[c] = 1'b1;
            starve_m[c] = 0; lock_m[c] = 1'b0; lock_hi_m[c] = 1'b0; lock_f_m[c] = 1'b0;
        end

        // Reset held two cycles.
        for (int i = 0; i < 2; i++) begin
            settle();
            for (int c = 0; c < NUM_CH; c++) begin
                chk("rst_in_rdy", c, in_rdy[c], 1'b0);
                chk("rst_out_vld", c, out_vld[c], 1'b0);
            end
            tick();
        end
        rst = 1'b0;
        settle();
        chk("rel_in_rdy", 3, in_rdy[3], 1'b1);
        tick();

        // Table vectors: push at N, same fields presented at N+1.
        for (int v = 0; v < 5; v++) begin
            drive(vecs[v].ch, vecs[v].in_p);
            settle(); tick();
            idle_all();
            settle();
            chk("tbl_vld", vecs[v].ch, out_vld[vecs[v].ch], 1'b1);
            chk("tbl_pkt", vecs[v].ch, dut_pkt(vecs[v].ch), vecs[v].exp_p);
            tick();
        end

        // Backpressure until full, then drain in order.
        out_rdy[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, mk(1'b0, 8'(i + 1)));
            step();
        end
        idle_all();
        settle();
        chk("full_rdy", 0, in_rdy[0], 1'b0);
        tick();
        out_rdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_order", 0, out_data[0], 32'(i + 1));
            chk("bp_rdy", 0, in_rdy[0], (i == 0) ? 1'b0 : 1'b1);
            tick();
        end
        settle();
        chk("bp_empty", 0, out_vld[0], 1'b0);
        tick();

        // Stalled LO presentation is locked even after an HI arrives.
        out_rdy[0] = 1'b0;
        drive(0, mk(1'b0, 8'h10)); step();
        drive(0, mk(1'b1, 8'h20)); settle();
        chk("lock_first", 0, out_data[0], 8'h10);
        tick();
        idle_all(); settle();
        chk("lock_hold_d", 0, out_data[0], 8'h10);
        chk("lock_hold_q", 0, out_qos[0], 1'b0);
        tick();
        out_rdy[0] = 1'b1; settle();
        chk("lock_pop_lo", 0, out_data[0], 8'h10);
        chk("lock_no_evt", 0, starve_evt[0], 1'b0);
        tick();
        settle();
        chk("lock_then_hi", 0, out_data[0], 8'h20);
        chk("lock_then_q", 0, out_qos[0], 1'b1);
        tick();
        settle();
        chk("lock_empty", 0, out_vld[0], 1'b0);
        tick();

        // Starvation bound: HI,HI,HI,LO(event),HI.
        out_rdy[0] = 1'b0;
        drive(0, mk(1'b1, 8'd1));  step();
        drive(0, mk(1'b1, 8'd2));  step();
        drive(0, mk(1'b1, 8'd3));  step();
        drive(0, mk(1'b0, 8'h80)); step();
        drive(0, mk(1'b1, 8'd4));  step();
        idle_all();
        out_rdy[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("starve_order", 0, out_data[0], st_d[i]);
            chk("starve_pulse", 0, starve_evt[0], st_e[i]);
            tick();
        end

        // Mid-operation reset flushes ch 6.
        out_rdy[6] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(6, mk(i[0], 8'(8'h60 + i)));
            step();
        end
        idle_all();
        settle();
        chk("mid_pre_vld", 6, out_vld[6], 1'b1);
        tick();
        rst = 1'b1;
        settle();
        chk("mid_rst_rdy", 6, in_rdy[6], 1'b0);
        tick();
        rst = 1'b0;
        out_rdy[6] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mid_flushed", 6, out_vld[6], 1'b0);
            chk("mid_rdy", 6, in_rdy[6], 1'b1);
            tick();
        end

        // Channel independence: ch 0 streams while ch 1 saturates and ch 2 stalls.
        out_rdy[1] = 1'b0; out_rdy[2] = 1'b0; out_rdy[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(0, mk(1'b0, 8'(i)));
            drive(1, mk(1'b1, 8'(i)));
            drive(2, mk(1'b0, 8'(i)));
            settle();
            chk("ind_rdy0", 0, in_rdy[0], 1'b1);
            if (i > 0) begin
                chk("ind_vld0", 0, out_vld[0], 1'b1);
                chk("ind_tput", 0, out_data[0], 32'(i - 1));
            end
            tick();
        end
        idle_all();
        for (int c = 0; c < NUM_CH; c++) out_rdy[c] = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                in_vld[c]  = 1'($urandom_range(0, 1));
                in_qos[c]  = 1'($urandom_range(0, 1));
                in_type[c] = 2'($urandom_range(0, 3));
                in_src[c]  = 6'($urandom_range(0, 63));
                in_tgt[c]  = 6'($urandom_range(0, 63));
                in_data[c] = 8'($urandom_range(0, 255));
                out_rdy[c] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
